// File: rtl/cpu_divide_iter.sv
// cpu_divide_iter
//   Iterative restoring divider for the M-extension DIV/DIVU/REM/REMU ops.
//   BITS_PER_CYCLE quotient bits are resolved per RUN cycle on operand
//   magnitudes, and the signs are applied when the result is registered.
//   Divide-by-zero and signed overflow bypass the iteration.
//
// Ports
//   i_clock        clock, all state on rising edge
//   i_reset        synchronous active-high reset (clears outputs too)
//   i_valid        request valid
//   o_ready        unit can accept a request this cycle
//   i_signed       1: DIV/REM, 0: DIVU/REMU
//   i_numerator    dividend (XLEN)
//   i_denominator  divisor (XLEN)
//   i_flush        abort any operation in flight; blocks acceptance
//   o_valid        result valid, held until i_ready
//   i_ready        consumer takes the result
//   o_result       quotient (XLEN)
//   o_remainder    remainder (XLEN)
module cpu_divide_iter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_numerator,
  input  logic [XLEN-1:0] i_denominator,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_remainder
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, den;
  logic            neg_q, neg_r;
  logic            accept;

  // Operand preparation at accept
  logic            num_neg, den_neg, is_div0, is_ovf;
  logic [XLEN-1:0] num_mag, den_mag;
  logic [XLEN-1:0] ld_quo, ld_rem;
  logic [CW-1:0]   ld_cnt;
  logic            ld_neg_q, ld_neg_r;

  // Iteration datapath
  logic [XLEN-1:0] r_nxt, q_nxt;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    o_ready   = (state == S_IDLE) || ((state == S_DONE) && i_ready);
    accept    = i_valid && o_ready && !i_flush;
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (i_ready) state_nxt = accept ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_flush) state_nxt = S_IDLE;
  end

  always_comb begin
    num_neg  = i_signed & i_numerator[XLEN-1];
    den_neg  = i_signed & i_denominator[XLEN-1];
    num_mag  = num_neg ? -i_numerator : i_numerator;
    den_mag  = den_neg ? -i_denominator : i_denominator;
    is_div0  = (i_denominator == '0);
    is_ovf   = i_signed && (i_numerator == MOST_NEG) && (i_denominator == '1);
    ld_quo   = num_mag;
    ld_rem   = '0;
    ld_cnt   = CW'(N);
    ld_neg_q = num_neg ^ den_neg;
    ld_neg_r = num_neg;
    // Special cases preload the final quotient/remainder and enter RUN with
    // the counter already at zero, so the normal result-register edge
    // publishes them one edge after accept.
    if (is_div0) begin
      ld_quo   = '1;
      ld_rem   = i_numerator;
      ld_cnt   = '0;
      ld_neg_q = 1'b0;
      ld_neg_r = 1'b0;
    end else if (is_ovf) begin
      ld_quo   = i_numerator;
      ld_rem   = '0;
      ld_cnt   = '0;
      ld_neg_q = 1'b0;
      ld_neg_r = 1'b0;
    end
  end

  // BITS_PER_CYCLE restoring steps; bit XLEN of the difference is the borrow
  // because the shifted partial remainder is always below twice the divisor.
  always_comb begin
    r_nxt   = rem;
    q_nxt   = quo;
    shifted = '0;
    diff    = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {r_nxt, q_nxt[XLEN-1]};
      diff    = shifted - {1'b0, den};
      q_nxt   = {q_nxt[XLEN-2:0], ~diff[XLEN]};
      r_nxt   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      den         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_remainder <= '0;
    end else begin
      state <= state_nxt;
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (accept) begin
        o_valid <= 1'b0;
        quo     <= ld_quo;
        rem     <= ld_rem;
        den     <= den_mag;
        cnt     <= ld_cnt;
        neg_q   <= ld_neg_q;
        neg_r   <= ld_neg_r;
      end else if ((state == S_DONE) && i_ready) begin
        o_valid <= 1'b0;
      end else if (state == S_RUN) begin
        if (cnt == '0) begin
          o_valid     <= 1'b1;
          o_result    <= neg_q ? -quo : quo;
          o_remainder <= neg_r ? -rem : rem;
        end else begin
          rem <= r_nxt;
          quo <= q_nxt;
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule
